sysbus_mem_responder: RTL and testbench
=======================================

SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 16'h0000: base of the decoded window on the system bus.
REQ-002 SHALL have parameter ADDR_BITS, default 8: word-address width, giving a 2**ADDR_BITS x 16 internal RAM.
REQ-003 SHALL have port Clock, input, 1: single clock; all state changes on posedge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port SysBusIn, input, 16: address during ALE and write data otherwise.
REQ-006 SHALL have port SysBusOut, output, 16: read data.
REQ-007 SHALL have port SysBusOe, output, 1: high when SysBusOut is to be driven onto the bus.
REQ-008 SHALL have ports ALE, nME, nOE, nWE, inputs, 1 each: initiator strobes; nME, nOE and nWE are active-low.
REQ-009 SHALL have port Sel, output, 1: the latched address hit the window.
REQ-010 SHALL have port ProtErr, output, 1: a write to the protected region was rejected (REQ-027).

Function
REQ-011 SHALL sample all strobes at posedge Clock only, with no combinational path from input to output.
REQ-012 SHALL implement the states IDLE, ADDR, READ and WRITE.
REQ-013 Address phase: ALE=1 at an edge SHALL load AddrReg from SysBusIn from any state, and enter ADDR.
REQ-014 At the same ALE edge, Sel SHALL load 1 iff SysBusIn[15:ADDR_BITS]==ADDR_BASE[15:ADDR_BITS], and 0 otherwise.
REQ-015 ALE has priority over every other strobe; an ALE edge during READ or WRITE SHALL abort that cycle and clear SysBusOe on the same edge.
REQ-016 Read: in ADDR with Sel=1, an edge sampling nME=0, nOE=0, nWE=1 SHALL enter READ.
REQ-017 On that edge, SysBusOut SHALL load RAM[AddrReg[ADDR_BITS-1:0]] and SysBusOe SHALL go to 1, so data is valid one cycle after the strobes are sampled.
REQ-018 In READ, SysBusOut and SysBusOe SHALL hold while nME=0.
REQ-019 In READ, the first edge sampling nME=1 SHALL clear SysBusOe and return the block to IDLE.
REQ-020 Write: in ADDR with Sel=1, an edge sampling nME=0, nWE=0 SHALL write SysBusIn to RAM[AddrReg] once and enter WRITE.
REQ-021 WRITE SHALL perform no further RAM writes, and SHALL return to IDLE on the first edge sampling nME=1.
REQ-022 nOE=0 together with nWE=0 SHALL be treated as a write, and SysBusOe SHALL never be asserted in that case.
REQ-023 With Sel=0, the block SHALL stay in ADDR with no RAM access and SysBusOe=0 until the next ALE.
REQ-024 In ADDR, nME=1 SHALL cause the block to remain in ADDR; the address stays valid for repeated strobes until the next ALE.
REQ-025 The address SHALL wrap through AddrReg[ADDR_BITS-1:0] only; upper bits are used solely for decode.

Reset
REQ-026 Reset=1 SHALL immediately force state IDLE, AddrReg=0, SysBusOut=16'h0000, SysBusOe=0, Sel=0 and ProtErr=0, including mid-READ or mid-WRITE; RAM contents are not reset.

Configuration
REQ-027 With macro SYSBUS_MEM_RESPONDER_WPROT_EN defined, a write to word addresses 0..15 SHALL leave the RAM unchanged and set ProtErr=1.
REQ-028 Under SYSBUS_MEM_RESPONDER_WPROT_EN, ProtErr SHALL stay at 1 until the next ALE edge or Reset.
REQ-029 Without SYSBUS_MEM_RESPONDER_WPROT_EN, every address SHALL be writable and ProtErr SHALL be tied to 0.

Verification
REQ-030 Reset sequence: assert Reset, then release -> all outputs 0 and state IDLE.
REQ-031 Write then read: ALE with SysBusIn=16'h0025, then nME=0, nWE=0 with data 16'hBEEF.
REQ-032 The read back, ALE with 16'h0025 then nME=0, nOE=0, SHALL give SysBusOut=16'hBEEF with SysBusOe=1 one cycle after the strobes are sampled, and SysBusOe=0 one cycle after nME=1 is sampled.
REQ-033 Decode miss with ADDR_BASE=16'h0000 and ALE address 16'h1200 -> Sel=0; read strobes -> SysBusOe stays 0; write strobes -> RAM unchanged.
REQ-034 Abort: ALE asserted during READ -> SysBusOe=0 on that edge, and the new address is latched.
REQ-035 Held write: nWE=0 held for 3 cycles while SysBusIn changes 16'h1111, then 16'h2222 -> RAM holds 16'h1111.
REQ-036 Protected write to address 16'h0003 with data 16'hAAAA: with the macro defined -> RAM unchanged and ProtErr=1 until the next ALE; with the macro undefined -> RAM=16'hAAAA and ProtErr=0.

Source files
------------

// File: rtl/sysbus_mem_responder.sv
// System-bus slave with a 2**ADDR_BITS x 16 RAM behind an ALE/nME/nOE/nWE strobe protocol.
// Optional write protection of word addresses 0..15: define SYSBUS_MEM_RESPONDER_WPROT_EN.
module sysbus_mem_responder #(
  parameter logic [15:0] ADDR_BASE = 16'h0000,
  parameter int          ADDR_BITS = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] SysBusIn,
  output logic [15:0] SysBusOut,
  output logic        SysBusOe,
  input  logic        ALE,
  input  logic        nME,
  input  logic        nOE,
  input  logic        nWE,
  output logic        Sel,
  output logic        ProtErr
);
  typedef enum logic [1:0] {IDLE, ADDR, READ, WRITE} state_t;

  state_t               state, next_state;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [15:0]          mem [2**ADDR_BITS];
  logic                 hit, wr_prot, wr_go, rd_start, ram_we;

  // Only the word index is kept; the upper address bits matter solely for decode at ALE.
  assign hit    = (SysBusIn >> ADDR_BITS) == (ADDR_BASE >> ADDR_BITS);
  assign ram_we = wr_go && !wr_prot;

  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else       state <= next_state;

  always_comb begin
    next_state = state;
    wr_go      = 1'b0;
    rd_start   = 1'b0;
    if (ALE) next_state = ADDR;
    else begin
      case (state)
        IDLE:  next_state = IDLE;
        // nWE wins over nOE so a simultaneous nOE/nWE is a write and never drives the bus.
        ADDR: if (Sel && !nME) begin
          if (!nWE) begin
            next_state = WRITE;
            wr_go      = 1'b1;
          end else if (!nOE) begin
            next_state = READ;
            rd_start   = 1'b1;
          end
        end
        READ:  if (nME) next_state = IDLE;
        WRITE: if (nME) next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      addr_reg  <= '0;
      SysBusOut <= 16'h0000;
      SysBusOe  <= 1'b0;
      Sel       <= 1'b0;
    end else if (ALE) begin
      addr_reg <= SysBusIn[ADDR_BITS-1:0];
      Sel      <= hit;
      SysBusOe <= 1'b0;
    end else if (rd_start) begin
      SysBusOut <= mem[addr_reg];
      SysBusOe  <= 1'b1;
    end else if (state == READ && nME) begin
      SysBusOe <= 1'b0;
    end

  always_ff @(posedge Clock)
    if (ram_we) mem[addr_reg] <= SysBusIn;

`ifdef SYSBUS_MEM_RESPONDER_WPROT_EN
  logic prot_err;
  assign wr_prot = (addr_reg >> 4) == '0;
  assign ProtErr = prot_err;

  // Sticky until the next address phase.
  always_ff @(posedge Clock or posedge Reset)
    if (Reset)                 prot_err <= 1'b0;
    else if (ALE)              prot_err <= 1'b0;
    else if (wr_go && wr_prot) prot_err <= 1'b1;
`else
  assign wr_prot = 1'b0;
  assign ProtErr = 1'b0;
`endif
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: vector table plus hand sequences for abort, held write, reset and protection.
module tb_sysbus_mem_responder;
  logic        Clock = 1'b0, Reset = 1'b0;
  logic [15:0] SysBusIn = 16'h0000, SysBusOut;
  logic        SysBusOe, ALE = 1'b0, nME = 1'b1, nOE = 1'b1, nWE = 1'b1, Sel, ProtErr;
  int          errs = 0, checks = 0;

`ifdef SYSBUS_MEM_RESPONDER_WPROT_EN
  localparam logic PEXP = 1'b1;
`else
  localparam logic PEXP = 1'b0;
`endif

  sysbus_mem_responder #(.ADDR_BASE(16'h0000), .ADDR_BITS(8)) dut (
    .Clock(Clock), .Reset(Reset), .SysBusIn(SysBusIn), .SysBusOut(SysBusOut), .SysBusOe(SysBusOe),
    .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE), .Sel(Sel), .ProtErr(ProtErr));

  always #5 Clock = ~Clock;

  typedef struct {
    logic ale, nme, noe, nwe;
    logic [15:0] din;
    logic oe, sel, prot;
    logic [15:0] dout;  // compared only when oe is expected high
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ale, input logic nme, input logic noe, input logic nwe, input logic [15:0] din);
    ALE = ale; nME = nme; nOE = noe; nWE = nwe; SysBusIn = din;
  endtask

  task automatic cyc();
    @(posedge Clock); #1;
  endtask

  function automatic vec_t v(logic ale, logic nme, logic noe, logic nwe, logic [15:0] din,
                             logic oe, logic sel, logic prot, logic [15:0] dout);
    vec_t r;
    r.ale = ale; r.nme = nme; r.noe = noe; r.nwe = nwe; r.din = din;
    r.oe = oe; r.sel = sel; r.prot = prot; r.dout = dout;
    return r;
  endfunction

  initial begin
    //             ale nme noe nwe din       oe sel prot  dout
    vecs.push_back(v(1, 1, 1, 1, 16'h0025, 0, 1, 0,    16'h0));    // address phase
    vecs.push_back(v(0, 0, 1, 0, 16'hBEEF, 0, 1, 0,    16'h0));    // write BEEF
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 1, 0,    16'h0));
    vecs.push_back(v(1, 1, 1, 1, 16'h0025, 0, 1, 0,    16'h0));
    vecs.push_back(v(0, 0, 0, 1, 16'h0000, 1, 1, 0,    16'hBEEF)); // read back
    vecs.push_back(v(0, 0, 0, 1, 16'h0000, 1, 1, 0,    16'hBEEF)); // held
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 1, 0,    16'h0));    // nME release drops Oe
    vecs.push_back(v(1, 1, 1, 1, 16'h1225, 0, 0, 0,    16'h0));    // decode miss
    vecs.push_back(v(0, 0, 0, 1, 16'h0000, 0, 0, 0,    16'h0));
    vecs.push_back(v(0, 0, 1, 0, 16'h5555, 0, 0, 0,    16'h0));
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 0, 0,    16'h0));
    vecs.push_back(v(1, 1, 1, 1, 16'h0025, 0, 1, 0,    16'h0));
    vecs.push_back(v(0, 0, 0, 1, 16'h0000, 1, 1, 0,    16'hBEEF)); // miss did not write
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 1, 0,    16'h0));
    vecs.push_back(v(1, 1, 1, 1, 16'h0030, 0, 1, 0,    16'h0));
    vecs.push_back(v(0, 0, 0, 0, 16'h1234, 0, 1, 0,    16'h0));    // nOE+nWE is a write
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 1, 0,    16'h0));
    vecs.push_back(v(1, 1, 1, 1, 16'h0030, 0, 1, 0,    16'h0));
    vecs.push_back(v(0, 0, 0, 1, 16'h0000, 1, 1, 0,    16'h1234));
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 1, 0,    16'h0));
    vecs.push_back(v(1, 1, 1, 1, 16'h0025, 0, 1, 0,    16'h0));
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 1, 0,    16'h0));    // idle in ADDR keeps address
    vecs.push_back(v(0, 1, 0, 1, 16'h0000, 0, 1, 0,    16'h0));
    vecs.push_back(v(0, 0, 0, 1, 16'h0000, 1, 1, 0,    16'hBEEF));
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 1, 0,    16'h0));
    vecs.push_back(v(1, 1, 1, 1, 16'h0003, 0, 1, 0,    16'h0));    // protected region
    vecs.push_back(v(0, 0, 1, 0, 16'hAAAA, 0, 1, PEXP, 16'h0));
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 1, PEXP, 16'h0));
    vecs.push_back(v(0, 1, 1, 1, 16'h0000, 0, 1, PEXP, 16'h0));    // sticky
    vecs.push_back(v(1, 1, 1, 1, 16'h0025, 0, 1, 0,    16'h0));    // ALE clears ProtErr

    // Reset state
    Reset = 1'b1; #1;
    chk("rst_out_async", SysBusOut, 16'h0);
    chk("rst_oe_async", {15'h0, SysBusOe}, 16'h0);
    cyc(); cyc();
    Reset = 1'b0;
    cyc();
    chk("rst_out", SysBusOut, 16'h0);
    chk("rst_oe", {15'h0, SysBusOe}, 16'h0);
    chk("rst_sel", {15'h0, Sel}, 16'h0);
    chk("rst_prot", {15'h0, ProtErr}, 16'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].ale, vecs[i].nme, vecs[i].noe, vecs[i].nwe, vecs[i].din);
      cyc();
      chk($sformatf("v%0d_oe", i), {15'h0, SysBusOe}, {15'h0, vecs[i].oe});
      chk($sformatf("v%0d_sel", i), {15'h0, Sel}, {15'h0, vecs[i].sel});
      chk($sformatf("v%0d_prot", i), {15'h0, ProtErr}, {15'h0, vecs[i].prot});
      if (vecs[i].oe) chk($sformatf("v%0d_out", i), SysBusOut, vecs[i].dout);
    end

    // Abort: ALE during READ drops Oe on that edge and latches the new address
    drive(0, 0, 0, 1, 16'h0); cyc();
    chk("abort_pre_oe", {15'h0, SysBusOe}, 16'h1);
    drive(1, 0, 0, 1, 16'h0030); cyc();
    chk("abort_oe", {15'h0, SysBusOe}, 16'h0);
    drive(0, 0, 0, 1, 16'h0); cyc();
    chk("abort_newaddr", SysBusOut, 16'h1234);
    drive(0, 1, 1, 1, 16'h0); cyc();

    // Held write: only the first sampled data lands
    drive(1, 1, 1, 1, 16'h0040); cyc();
    drive(0, 0, 1, 0, 16'h1111); cyc();
    drive(0, 0, 1, 0, 16'h2222); cyc(); cyc();
    drive(0, 1, 1, 1, 16'h0); cyc();
    drive(1, 1, 1, 1, 16'h0040); cyc();
    drive(0, 0, 0, 1, 16'h0); cyc();
    chk("held_write", SysBusOut, 16'h1111);

    // Reset mid-READ takes effect without a clock edge
    #2 Reset = 1'b1; #1;
    chk("midrd_rst_oe", {15'h0, SysBusOe}, 16'h0);
    chk("midrd_rst_out", SysBusOut, 16'h0);
    chk("midrd_rst_sel", {15'h0, Sel}, 16'h0);
    drive(0, 1, 1, 1, 16'h0);
    cyc();
    Reset = 1'b0;
    cyc();
    chk("post_rst_oe", {15'h0, SysBusOe}, 16'h0);

    // Protected address read back
    drive(1, 1, 1, 1, 16'h0003); cyc();
    drive(0, 0, 0, 1, 16'h0); cyc();
    chk("prot_rd_oe", {15'h0, SysBusOe}, 16'h1);
`ifdef SYSBUS_MEM_RESPONDER_WPROT_EN
    checks++;
    if (SysBusOut === 16'hAAAA) begin
      errs++;
      $display("FAIL prot_rd_data: got %h required anything but aaaa", SysBusOut);
    end
`else
    chk("prot_rd_data", SysBusOut, 16'hAAAA);
`endif
    drive(0, 1, 1, 1, 16'h0); cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
